// File: rtl/uart_autobaud.sv
// uart_autobaud: measures a 0x55 sync frame on rx and drives the receiver's clocks-per-bit (option: UART_AUTOBAUD_CHECK_EN)
module uart_autobaud #(
  parameter int COUNTER_WIDTH = 24,
  parameter int DEFAULT_DELAY = 1250,
  parameter int MIN_SEG_CLKS = 8,
  parameter int IDLE_CLKS = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic uart_rxpin,
  input  logic start,
  output logic busy,
  output logic locked,
  output logic cal_error,
  output logic rx_enable,
  output logic [COUNTER_WIDTH-1:0] delay_frames
);
  localparam int SW = COUNTER_WIDTH + 3;
  localparam int IW = $clog2(IDLE_CLKS + 1);
  typedef enum logic [2:0] {IDLE, WAIT_IDLE, WAIT_START, MEASURE, STOP_CHECK, LOCKED} state_t;
  state_t state, nxt;
  logic rx_s1, rx_s2, rx_d, fall, rise, edg, hold, err, tol_bad;
  logic [IW-1:0] idle_cnt;
  logic [SW-1:0] span, seg, seg_len;
  logic [SW:0] tgt;
  logic [2:0] fall_cnt;
  assign fall = rx_d & ~rx_s2;
  assign rise = ~rx_d & rx_s2;
  assign edg = fall | rise;
  assign seg_len = seg + 1'b1;
  assign tgt = ({1'b0, span} + (SW+1)'(4)) >> 3;
`ifdef UART_AUTOBAUD_CHECK_EN
  logic [SW-1:0] w0, diff;
  logic first;
  assign diff = seg_len > w0 ? seg_len - w0 : w0 - seg_len;
  assign tol_bad = !first && diff > (w0 >> 2);
  // latch the start-bit width as the reference for every later segment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w0 <= '0;
      first <= 1'b1;
    end else if (state == WAIT_START) begin
      first <= 1'b1;
    end else if (state == MEASURE && edg && first) begin
      w0 <= seg_len;
      first <= 1'b0;
    end
  end
`else
  assign tol_bad = 1'b0;
`endif
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  // next state and error detection; errors always fall back to WAIT_IDLE
  always_comb begin
    nxt = state;
    err = 1'b0;
    case (state)
      IDLE, LOCKED: nxt = start ? WAIT_IDLE : state;
      WAIT_IDLE:    nxt = (rx_s2 && idle_cnt == IW'(IDLE_CLKS - 1)) ? WAIT_START : state;
      WAIT_START:   nxt = fall ? MEASURE : state;
      MEASURE: begin
        err = &span || (edg && (seg_len < SW'(MIN_SEG_CLKS) || tol_bad));
        nxt = err ? WAIT_IDLE : (fall && fall_cnt == 3'd4) ? STOP_CHECK : state;
      end
      STOP_CHECK: begin
        err = hold ? fall : (&seg || (rise && (seg_len < SW'(MIN_SEG_CLKS) || tol_bad)));
        nxt = err ? WAIT_IDLE : (hold && {1'b0, seg} + (SW+1)'(2) >= tgt) ? LOCKED : state;
      end
      default: nxt = IDLE;
    endcase
  end
  // outputs decoded from state
  always_comb begin
    busy = state != IDLE && state != LOCKED;
    locked = state == LOCKED;
    rx_enable = !busy;
  end
  // synchroniser, measurement counters and calibrated result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {rx_s1, rx_s2, rx_d} <= 3'b111;
      idle_cnt <= '0;
      span <= '0;
      seg <= '0;
      fall_cnt <= '0;
      hold <= 1'b0;
      cal_error <= 1'b0;
      delay_frames <= COUNTER_WIDTH'(DEFAULT_DELAY);
    end else begin
      {rx_s1, rx_s2, rx_d} <= {uart_rxpin, rx_s1, rx_s2};
      idle_cnt <= (state == WAIT_IDLE && rx_s2) ? idle_cnt + 1'b1 : '0;
      span <= state == MEASURE ? span + 1'b1 : state == STOP_CHECK ? span : '0;
      seg <= ((state == MEASURE && !edg) || (state == STOP_CHECK && (hold || !rise))) ? seg + 1'b1 : '0;
      fall_cnt <= state == WAIT_START ? 3'd1 : (state == MEASURE && fall) ? fall_cnt + 3'd1 : fall_cnt;
      hold <= state == STOP_CHECK && (hold || rise);
      cal_error <= err;
      if (state == STOP_CHECK && nxt == LOCKED) delay_frames <= tgt[COUNTER_WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_uart_autobaud.sv
// tb_uart_autobaud: randomized sync frames checked against a frame-level calibration model
`timescale 1ns/1ps
module tb_uart_autobaud;
  logic clk = 1'b0, rst_n = 1'b0, uart_rxpin = 1'b1, start = 1'b0;
  logic busy, locked, cal_error, rx_enable;
  logic [23:0] delay_frames;
  int vectors = 0, miscompares = 0, err_pulses = 0, exp_delay = 1250;
  int seg_w[9];
  uart_autobaud dut (
    .clk(clk), .rst_n(rst_n), .uart_rxpin(uart_rxpin), .start(start),
    .busy(busy), .locked(locked), .cal_error(cal_error),
    .rx_enable(rx_enable), .delay_frames(delay_frames)
  );
  always #5 clk = ~clk;
  always @(posedge clk) #2 if (cal_error) err_pulses++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input int n);
    uart_rxpin = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic set_frame(input int w);
    for (int i = 0; i < 9; i++) seg_w[i] = w;
  endtask
  task automatic run_frame(input bit short_stop, input bit poke);
    int bad, span, tgt, e0, n, stop;
    if (!busy) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_busy", busy, 1);
      check("start_locked", locked, 0);
      check("start_rx_en", rx_enable, 0);
    end
    bad = -1;
    span = 0;
    for (int i = 0; i < 9; i++) begin
      if (bad < 0 && seg_w[i] < 8) bad = i;
`ifdef UART_AUTOBAUD_CHECK_EN
      if (bad < 0 && i > 0 && (seg_w[i] > seg_w[0] ? seg_w[i] - seg_w[0] : seg_w[0] - seg_w[i]) > (seg_w[0] >> 2)) bad = i;
`endif
      if (i < 8) span += seg_w[i];
    end
    tgt = (span + 4) / 8;
    stop = short_stop ? tgt / 2 : tgt + 5;
    e0 = err_pulses;
    drive(1'b1, 80);
    for (int i = 0; i < 9 && (bad < 0 || i <= bad); i++) begin
      uart_rxpin = logic'(i % 2);
      start = poke && i == 2;
      @(negedge clk);
      start = 1'b0;
      repeat (seg_w[i] - 1) @(negedge clk);
    end
    if (bad < 0 && stop >= tgt) begin
      uart_rxpin = 1'b1;
      n = 0;
      while (!locked && n < tgt + 20) begin
        @(negedge clk);
        n++;
      end
      check("lock_latency_ok", n >= tgt && n <= tgt + 4, 1);
      exp_delay = tgt;
      check("lock_delay", delay_frames, exp_delay);
      check("lock_rx_en", rx_enable, 1);
      check("lock_busy", busy, 0);
      check("lock_no_err", err_pulses - e0, 0);
    end else begin
      if (bad < 0) drive(1'b1, stop);
      if (bad < 0 || bad % 2 == 1) drive(1'b0, 20);
      drive(1'b1, 80);
      check("err_pulses", err_pulses - e0, 1);
      check("err_busy", busy, 1);
      check("err_locked", locked, 0);
      check("err_delay", delay_frames, exp_delay);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_locked", locked, 0);
    check("rst_cal_error", cal_error, 0);
    check("rst_rx_en", rx_enable, 1);
    check("rst_delay", delay_frames, 1250);
    rst_n = 1'b1;
    @(negedge clk);
    set_frame(100);
    seg_w[0] = 4;
    run_frame(0, 0);
    set_frame(100);
    run_frame(0, 0);
    seg_w[7] = 103;
    run_frame(0, 0);
    seg_w[7] = 104;
    run_frame(0, 0);
    set_frame(100);
    seg_w[4] = 140;
    run_frame(0, 0);
    set_frame(100);
    run_frame(0, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive(1'b1, 80);
    drive(1'b0, 50);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_delay = 1250;
    check("meas_rst_busy", busy, 0);
    check("meas_rst_locked", locked, 0);
    check("meas_rst_rx_en", rx_enable, 1);
    check("meas_rst_delay", delay_frames, 1250);
    drive(1'b1, 20);
    set_frame(100);
    run_frame(0, 0);
    set_frame(52);
    run_frame(0, 0);
    set_frame(8);
    run_frame(0, 0);
    set_frame(60);
    run_frame(1, 0);
    for (int f = 0; f < 20; f++) begin
      int base, j;
      base = int'($urandom_range(120, 8));
      j = int'($urandom_range(base / 3, 0));
      for (int i = 0; i < 9; i++) begin
        seg_w[i] = base + int'($urandom_range(2 * j, 0)) - j;
        if (seg_w[i] < 1) seg_w[i] = 1;
      end
      run_frame($urandom_range(9, 0) == 0, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
